// File: rtl/hyperram_pkg.sv
// Shared definitions for the HyperRAM controller and its device-side responder:
// FSM encoding, command/address bit positions and transfer sizes.
package hyperram_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CA   = 3'd1,
        LAT  = 3'd2,
        DATA = 3'd3,
        END  = 3'd4
    } state_t;

    localparam int CA_RW     = 47;
    localparam int CA_AS     = 46;
    localparam int CA_BURST  = 45;
    localparam int CA_ROW_HI = 35;
    localparam int CA_ROW_LO = 16;
    localparam int CA_COL_HI = 2;

    localparam int BYTES_PER_WORD = 4;
    localparam int CA_BYTES       = 6;

endpackage

// File: rtl/hyperram_resp_mem.sv
// Word-wide register file with per-byte write enables and a combinational read
// port, so read bytes can be registered on the same edge that enters DATA.
module hyperram_resp_mem
    import hyperram_pkg::*;
#(
    parameter int ADDR_BITS = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [BYTES_PER_WORD-1:0] be,
    input  logic [ADDR_BITS-1:0]      waddr,
    input  logic [31:0]               wdata,
    input  logic [ADDR_BITS-1:0]      raddr,
    output logic [31:0]               rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hyperram_responder.sv
// Device-side HyperRAM target: decodes the 6-byte CA phase, waits `latency`
// cycles, then captures a byte-masked write word or streams a read word.
module hyperram_responder
    import hyperram_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs_bar,
    input  logic [7:0]          dq_in,
    output logic [7:0]          dq_out,
    output logic                dq_oeb,
    input  logic                rwds_in,
    output logic                rwds_out,
    output logic                rwds_oeb,
    input  logic [5:0]          latency,
    output logic                proto_err,
    output logic [CNT_BITS-1:0] txn_count,
    output logic [2:0]          state
);

    localparam logic [2:0] CA_LAST   = 3'(CA_BYTES - 1);
    localparam logic [1:0] DATA_LAST = 2'(BYTES_PER_WORD - 1);

    state_t          st, st_n;
    logic [47:0]     ca, ca_cur;
    logic [2:0]      ca_idx;
    logic [5:0]      lat_cnt;
    logic [1:0]      dat_idx;
    logic [23:0]     wbuf;
    logic [2:0]      wmask;
    logic [22:0]     idx_full;
    logic [ADDR_BITS-1:0] widx;
    logic [31:0]     rd_word;
    logic            is_read, ca_ok;
    logic            drive, err, commit, inc;
    logic [1:0]      drv_k;
    logic            unused_ok;

    assign state = st;

    // The final CA byte is merged in combinationally so a zero-latency read
    // can address memory on the very edge that leaves CA.
    always_comb begin
        ca_cur = ca;
        if (st == CA) ca_cur[8*(CA_BYTES-1-int'(ca_idx)) +: 8] = dq_in;
    end

    assign is_read   = ca_cur[CA_RW];
    assign ca_ok     = !ca_cur[CA_AS] && ca_cur[CA_BURST];
    assign idx_full  = {ca_cur[CA_ROW_HI:CA_ROW_LO], ca_cur[CA_COL_HI:0]};
    assign widx      = idx_full[ADDR_BITS-1:0];
    assign unused_ok = &{1'b0, ca_cur[44:36], ca_cur[15:3], idx_full};

    always_comb begin
        st_n   = st;
        drive  = 1'b0;
        drv_k  = 2'd0;
        err    = 1'b0;
        commit = 1'b0;
        inc    = 1'b0;
        case (st)
            IDLE: if (!cs_bar) st_n = CA;
            CA: begin
                if (cs_bar) begin
                    st_n = IDLE;
                    err  = 1'b1;
                end else if (ca_idx == CA_LAST) begin
                    if (!ca_ok) begin
                        st_n = END;
                        err  = 1'b1;
                    end else if (latency == 6'd0) begin
                        st_n  = DATA;
                        drive = is_read;
                    end else begin
                        st_n = LAT;
                    end
                end
            end
            LAT: begin
                if (cs_bar) begin
                    st_n = IDLE;
                    err  = 1'b1;
                end else if (lat_cnt == latency) begin
                    st_n  = DATA;
                    drive = is_read;
                end
            end
            DATA: begin
                if (cs_bar) begin
                    st_n = IDLE;
                    err  = 1'b1;
                end else if (dat_idx == DATA_LAST) begin
                    st_n   = END;
                    inc    = 1'b1;
                    commit = !is_read;
                end else begin
                    drive = is_read;
                    drv_k = dat_idx + 2'd1;
                end
            end
            END:     if (cs_bar) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            dq_out    <= 8'd0;
            dq_oeb    <= 1'b1;
            rwds_out  <= 1'b0;
            rwds_oeb  <= 1'b1;
            proto_err <= 1'b0;
            txn_count <= '0;
            ca_idx    <= 3'd0;
            lat_cnt   <= 6'd0;
            dat_idx   <= 2'd0;
        end else begin
            st <= st_n;
            if (st == IDLE) ca_idx <= 3'd1;
            else if (st == CA) ca_idx <= ca_idx + 3'd1;
            if (st_n == LAT && st != LAT) lat_cnt <= 6'd1;
            else if (st == LAT) lat_cnt <= lat_cnt + 6'd1;
            if (st_n == DATA && st != DATA) dat_idx <= 2'd0;
            else if (st == DATA) dat_idx <= dat_idx + 2'd1;
            if (drive) begin
                dq_out   <= rd_word[8*drv_k +: 8];
                dq_oeb   <= 1'b0;
                rwds_out <= 1'b1;
                rwds_oeb <= 1'b0;
            end else if (st_n != DATA) begin
                dq_oeb   <= 1'b1;
                rwds_out <= 1'b0;
                rwds_oeb <= 1'b1;
            end
            if (err) proto_err <= 1'b1;
            if (inc) txn_count <= txn_count + 1'b1;
        end
    end

    // CA and write staging hold no state worth resetting.
    always_ff @(posedge clk) begin
        if (st == IDLE) ca[47:40] <= dq_in;
        else if (st == CA) ca <= ca_cur;
        if (st == DATA && dat_idx != DATA_LAST) begin
            wbuf[8*dat_idx +: 8] <= dq_in;
            wmask[dat_idx]       <= rwds_in;
        end
    end

    hyperram_resp_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
        .clk   (clk),
        .we    (commit && !reset),
        .be    (~{rwds_in, wmask}),
        .waddr (widx),
        .wdata ({dq_in, wbuf}),
        .raddr (widx),
        .rdata (rd_word)
    );

endmodule

// File: doc/hyperram_responder.md
Name: hyperram_responder

Overview:
- Synthesizable HyperRAM target (device-side model) for the other end of the CA/WAIT/DATA byte-per-clk protocol driven by our `hyperram` controller.
- Decodes the 6-byte command/address (CA) phase and waits a configurable latency.
- Then either captures 4 byte-masked write bytes into a small register-file memory, or drives 4 read bytes with RWDS strobe.
- Used as an on-chip loopback target for LA-driven bring-up and as the bench counterpart for controller verification.

Parameters:
- ADDR_BITS, 4, memory index width; DEPTH = 2**ADDR_BITS words of 32 bits.
- CNT_BITS, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock (same clock as the controller; one protocol byte per clk).
- reset  input  1  reset, synchronous, active-high.
- cs_bar  input  1  chip select, active low.
- dq_in  input  8  bus from initiator.
- dq_out  output  8  read data to initiator.
- dq_oeb  output  1  dq output enable, active low.
- rwds_in  input  1  write byte mask from initiator (1 = byte masked).
- rwds_out  output  1  read data strobe.
- rwds_oeb  output  1  rwds output enable, active low.
- latency  input  6  cycles between last CA byte and first data byte (= controller WAIT_LATENCY+1).
- proto_err  output  1  sticky protocol-error flag.
- txn_count  output  CNT_BITS  completed read+write transactions, wraps.
- state  output  3  FSM state for bench/LA.

Behaviour:
Reset (sync):
- state=IDLE; dq_oeb=1, rwds_oeb=1, dq_out=0, rwds_out=0; proto_err=0; txn_count=0.
- Memory contents are NOT reset.
- Reset mid-transaction aborts immediately; no partial write is committed.

States: IDLE, CA, LAT, DATA, END.
- IDLE:
  - Any cycle with cs_bar=0 is CA byte 0; sample dq_in into ca[47:40] -> CA with byte index 1.
- CA:
  - Sample one byte per cycle into ca[47:40]..ca[7:0] (MSB first).
  - After byte 5 is sampled: if latency==0 -> DATA, else -> LAT.
- LAT:
  - Count `latency` cycles total; then -> DATA with data index 0.
  - `latency` is sampled continuously; it must be held stable during a transaction.
- Decode (ca valid from LAT onward):
  - is_read = ca[47].
  - ca[46] must be 0 and ca[45] must be 1. Otherwise set proto_err, go to END without driving or writing.
  - Word index = {ca[35:16], ca[2:0]}[ADDR_BITS-1:0]; upper bits are ignored, so addresses alias (wrap).
- DATA, read:
  - During data cycle k (k=0..3): dq_oeb=0, rwds_oeb=0, rwds_out=1, dq_out=mem[idx][8k+7:8k].
  - Values are valid in the same cycle the state is DATA(k); the output register is loaded on the edge entering that cycle.
  - After k=3: txn_count+1 -> END.
- DATA, write:
  - At data cycle k, sample dq_in and rwds_in into the byte buffer.
  - At the k=3 edge, commit all 4 bytes in one cycle: byte k is written only if its sampled rwds_in was 0.
  - Then txn_count+1 -> END.
- END:
  - Outputs released (oeb=1).
  - Stay until cs_bar=1, then -> IDLE.
- Abort:
  - cs_bar=1 in CA, LAT, or DATA -> IDLE next cycle, proto_err set, outputs released, no commit, txn_count unchanged.
- Back-to-back: cs_bar=1 for a single cycle is sufficient to return to IDLE; the next cycle may start a new CA.
- Write and read of the same index in consecutive transactions return the committed data (no hazard, since commit precedes END).

Decomposition:
- Shared package hyperram_pkg:
  - state enum.
  - CA bit-position constants (CA_RW=47, CA_AS=46, CA_BURST=45, CA_ROW_HI=35, CA_ROW_LO=16, CA_COL_HI=2).
  - BYTES_PER_WORD=4 and CA_BYTES=6 constants, shared with the controller.
- One sub-module, hyperram_resp_mem:
  - DEPTH x 32 register file with a 4-bit byte-enable write port and an asynchronous read port.

Test Plan:
- Controller WAIT_LATENCY=4 with responder latency=5. Write addr 0x5, data 0xCAFEBABE, mask 0000 -> mem[5]=0xCAFEBABE; txn_count=1; proto_err=0; controller returns to IDLE.
- Read addr 0x5 -> responder drives rwds=1 with bytes BE,BA,FE,CA on 4 consecutive cycles; controller data_in=0xCAFEBABE; txn_count=2.
- Write addr 0x5, data 0x11223344, mask 0101 -> mem[5]=0x11FE33BE; a subsequent read returns 0x11FE33BE.
- Aliasing with ADDR_BITS=4: write addr 0x15, data 0xDEADBEEF -> a read of addr 0x5 returns 0xDEADBEEF.
- Force cs_bar=1 in the cycle of data byte 2 of a write to addr 0x3 (prior contents 0x0) -> mem[3] stays 0x0; proto_err=1; state=IDLE next cycle; txn_count unchanged.
- CA with ca[46]=1 -> no dq/rwds drive (oeb stay 1), no write, proto_err=1. Assert reset in LAT -> state=IDLE, proto_err=0, outputs released.
